// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the decode-to-execute control struct.
// The struct width sets CTRL_W for the decode-to-execute stage register.
package pipeline_pkg;

    localparam int PIPE_DATA_W = 128;
    localparam int PIPE_CNT_W  = 16;

    typedef struct packed {
        logic [4:0] alu_op;
        logic [1:0] src_a_sel;
        logic [1:0] src_b_sel;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       branch;
        logic       jump;
        logic [1:0] wb_sel;
    } ex_ctrl_t;

    localparam int EX_CTRL_W = $bits(ex_ctrl_t);

endpackage

// File: rtl/pipe_slot.sv
// One valid+data+ctrl storage slot with load and clear.
// Clear drops valid and zeroes ctrl but keeps the payload; only reset zeroes data.
module pipe_slot #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d,  data_q;
    logic [CTRL_W-1:0] ctrl_d,  ctrl_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            ctrl_d  = load_ctrl;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipeline_stage_register.sv
// Valid/ready pipeline stage register with flush, bubble insertion and a saturating stall counter.
// Define PIPE_SKID_BUFFER_EN for a registered in_ready backed by a second (skid) slot.
module pipeline_stage_register
    import pipeline_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = EX_CTRL_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    logic              in_fire;
    logic              out_fire;
    logic              stall;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_ld_data;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clock     (clock),
        .reset     (reset),
        .clear     (main_clear),
        .load      (main_load),
        .load_data (main_ld_data),
        .load_ctrl (main_ld_ctrl),
        .valid     (main_valid),
        .data      (main_data),
        .ctrl      (main_ctrl)
    );

    assign out_fire = main_valid && out_ready;
    assign stall    = main_valid && !out_ready;
    assign in_fire  = in_valid && in_ready;

`ifdef PIPE_SKID_BUFFER_EN
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
    );

    // Straight from a flop, so out_ready never reaches in_ready combinationally.
    assign in_ready = !skid_valid;

    always_comb begin
        main_load    = 1'b0;
        main_clear   = 1'b0;
        main_ld_data = in_data;
        main_ld_ctrl = in_ctrl;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
                main_load    = 1'b1;
                main_ld_data = skid_data;
                main_ld_ctrl = skid_ctrl;
                skid_clear   = 1'b1;
            end else if (in_fire) begin
                main_load = 1'b1;
            end else if (out_fire) begin
                main_clear = 1'b1;
            end
        end else if (in_fire) begin
            skid_load = 1'b1;
        end
    end
`else
    assign in_ready = !main_valid || out_ready;

    always_comb begin
        main_ld_data = in_data;
        main_ld_ctrl = in_ctrl;
        main_load    = in_fire && !flush;
        main_clear   = flush || (out_fire && !in_fire);
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid   = main_valid;
    assign out_data    = main_data;
    assign out_ctrl    = main_ctrl;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register: directed scenarios plus random traffic against a queue model.
// Expectations follow PIPE_SKID_BUFFER_EN when it is defined for the build.
module tb_pipeline_stage_register;

    localparam int DATA_W  = 128;
    localparam int CTRL_W  = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    ent_t              mq[$];
    logic [DATA_W-1:0] m_last;
    int                m_cnt;

    always #5 clock = ~clock;

    pipeline_stage_register #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ctrl    (out_ctrl),
        .stall_count (stall_count)
    );

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_in_ready(input bit ordy);
`ifdef PIPE_SKID_BUFFER_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || ordy;
`endif
    endfunction

    // One clock: drive, compare against the model, clock it, advance the model.
    task automatic cycle(input bit iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input bit ordy, input bit fl, input bit rst);
        bit   exp_rdy;
        ent_t e;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        exp_rdy = model_in_ready(ordy);
        check_eq("out_valid", DATA_W'(out_valid), DATA_W'(mq.size() > 0));
        check_eq("out_data", out_data, (mq.size() > 0) ? mq[0].d : m_last);
        check_eq("out_ctrl", DATA_W'(out_ctrl), (mq.size() > 0) ? DATA_W'(mq[0].c) : '0);
        check_eq("stall_count", DATA_W'(stall_count), DATA_W'(m_cnt));
        check_eq("in_ready", DATA_W'(in_ready), DATA_W'(exp_rdy));
        @(posedge clock);
        if (rst) begin
            mq.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            if (mq.size() > 0 && !ordy && m_cnt < CNT_MAX) m_cnt++;
            if (fl) begin
                if (mq.size() > 0) m_last = mq[0].d;
                mq.delete();
            end else begin
                if (mq.size() > 0 && ordy) begin
                    m_last = mq[0].d;
                    void'(mq.pop_front());
                end
                if (iv && exp_rdy) begin
                    e.d = d;
                    e.c = c;
                    mq.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        m_last = '0; m_cnt = 0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_out_valid", DATA_W'(out_valid), '0);
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_out_ctrl", DATA_W'(out_ctrl), '0);
        check_eq("rst_stall_count", DATA_W'(stall_count), '0);
        reset = 1'b0;
        #1;
        check_eq("rst_in_ready", DATA_W'(in_ready), 128'd1);

        // Streaming 1..10 with no backpressure.
        for (int i = 1; i <= 10; i++) cycle(1'b1, DATA_W'(i), CTRL_W'(16'h0100 + i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("stream_last", out_data, 128'd10);
        check_eq("stream_stalls", DATA_W'(stall_count), '0);

        // Bubble: one idle input cycle in the stream.
        for (int i = 0; i < 6; i++) cycle(i != 2, DATA_W'(32 + i), CTRL_W'(16'h0F00 + i), 1'b1, 1'b0, 1'b0);

        // Stall: hold 0xA5 for four cycles, offer 0x5A in the first stall cycle.
        do_reset();
        cycle(1'b1, 128'hA5, 16'h00A5, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 128'h5A, 16'h005A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, rnd_data(), 16'(i), 1'b0, 1'b0, 1'b0);
        check_eq("stall_hold_data", out_data, 128'hA5);
        check_eq("stall_count4", DATA_W'(stall_count), 128'd4);
`ifdef PIPE_SKID_BUFFER_EN
        check_eq("stall_skid_in_ready", DATA_W'(in_ready), '0);
`endif
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with entries held and an input offered in the same cycle.
        do_reset();
        cycle(1'b1, 128'h11, 16'h0011, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 128'h22, 16'h0022, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 128'h33, 16'h0033, 1'b0, 1'b1, 1'b0);
        check_eq("flush_out_valid", DATA_W'(out_valid), '0);
        check_eq("flush_out_ctrl", DATA_W'(out_ctrl), '0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Saturation of the stall counter.
        do_reset();
        cycle(1'b1, 128'h77, 16'h0077, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("stall_saturate", DATA_W'(stall_count), 128'd15);

        // Reset in the middle of a stall.
        cycle(1'b1, 128'h99, 16'h0099, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_mid_valid", DATA_W'(out_valid), '0);
        check_eq("rst_mid_data", out_data, '0);
        check_eq("rst_mid_count", DATA_W'(stall_count), '0);
        check_eq("rst_mid_in_ready", DATA_W'(in_ready), 128'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7, rnd_data(), CTRL_W'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_register.md
PIPELINE_STAGE_REGISTER -- requirements
Module: pipeline_stage_register

Interface
REQ-001 Parameter: DATA_W, 128, width of payload bus (pc, operands, immediate, func fields).
REQ-002 Parameter: CTRL_W, 16, width of control bus (enables, mux selects, ALU op); zeroed on bubble.
REQ-003 Parameter: CNT_W, 16, width of stall counter.
REQ-004 Port: clock  in  1  clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  reset, synchronous, active-high.
REQ-006 Port: flush  in  1  synchronous kill of stage contents (branch/jump redirect).
REQ-007 Port: in_valid  in  1  upstream holds valid instruction.
REQ-008 Port: in_ready  out  1  stage accepts input this cycle.
REQ-009 Port: in_data  in  DATA_W  upstream payload.
REQ-010 Port: in_ctrl  in  CTRL_W  upstream control bits.
REQ-011 Port: out_valid  out  1  stage holds valid instruction.
REQ-012 Port: out_ready  in  1  downstream accepts output this cycle.
REQ-013 Port: out_data  out  DATA_W  registered payload.
REQ-014 Port: out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0.
REQ-015 Port: stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Input transfer SHALL occur iff in_valid && in_ready; output transfer iff out_valid && out_ready.
REQ-017 Latency SHALL be 1 cycle: data accepted at edge N appears on out_* after edge N.
REQ-018 While out_valid=1 and out_ready=0, out_data/out_ctrl SHALL hold stable (stall).
REQ-019 Simultaneous output drain and input accept SHALL load new entry; out_valid stays 1.
REQ-020 Drain with no input accept SHALL set out_valid=0 and out_ctrl=0 (bubble); out_data retains last value.
REQ-021 flush=1 SHALL, at next edge, set out_valid=0, out_ctrl=0, empty all storage; any input transfer in that cycle is discarded.
REQ-022 Priority SHALL be reset > flush > transfer.
REQ-023 stall_count SHALL increment by 1 per stall cycle, saturate at all-ones, clear only on reset.
REQ-024 in_data/in_ctrl SHALL be ignored when in_valid=0.

Reset
REQ-025 On reset: out_valid=0, out_data=0, out_ctrl=0, stall_count=0, skid slot empty.
REQ-026 In first cycle after reset deassertion, in_ready SHALL be 1.
REQ-027 Reset asserted mid-stall SHALL discard held and skid entries without output transfer.

Configuration
REQ-028 Macro PIPE_SKID_BUFFER_EN SHALL select ready-path implementation.
REQ-029 Without macro: in_ready = !out_valid || out_ready (combinational), single storage slot.
REQ-030 With macro: in_ready SHALL be a flop equal to "skid slot empty"; input accepted while output stalls goes to skid slot; on drain, skid entry moves to output, in_ready returns 1 next cycle; no combinational path out_ready->in_ready; no entry lost or duplicated.
REQ-031 Externally visible order and data SHALL be identical in both configurations; only in_ready timing differs.

Structure
REQ-032 Shared package pipeline_pkg SHALL hold default width constants and the packed ex_ctrl_t control struct whose width sets CTRL_W for the decode-to-execute instance.
REQ-033 Sub-module pipe_slot (one valid+data+ctrl register with load and clear) SHALL be instantiated once (main) and, with PIPE_SKID_BUFFER_EN, once more (skid).

Verification
REQ-034 Streaming: in_valid=1 every cycle, out_ready=1, data 1..10 -> out data 1..10 one cycle later, no gaps, stall_count=0.
REQ-035 Stall: load 0xA5, out_ready=0 for 4 cycles -> out_data=0xA5 held, stall_count=4; in skid mode second input 0x5A captured, in_ready=0, then 0xA5, 0x5A in order.
REQ-036 Flush: stage holds 0x11, skid holds 0x22, flush=1 with in_valid=1 data 0x33 -> next cycle out_valid=0, out_ctrl=0, 0x11/0x22/0x33 never emitted.
REQ-037 Bubble: in_valid=0 for one cycle in stream -> out_valid=0 and out_ctrl=0 for exactly one cycle.
REQ-038 Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_count=15.
REQ-039 Reset mid-stall: valid entry held, reset=1 one cycle -> out_valid=0, out_data=0, stall_count=0, in_ready=1 next cycle.
